// File: rtl/timer_pkg.sv
// Shared definitions for the timer/counter blocks of this clock domain.
package timer_pkg;

  // Counter width shared with the free-running up-counter.
  localparam int unsigned DEFAULT_WIDTH = 12;

  // Countdown timer control states; busy/done are decoded from these.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_e;

endpackage : timer_pkg

// File: rtl/countdown_timer.sv
// Programmable down-counter with a one-cycle terminal-count pulse and
// optional auto-reload. Command priority each cycle:
// reset > load > pause > start > tick.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             tick,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // Next-state and datapath: load overrides everything, then per-state behaviour.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // Any concurrent tick is deliberately dropped.
      reload_d = load_value;
      count_d  = load_value;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Starting from zero would run with nothing to count.
          if (!pause && start && (count_q != '0)) begin
            state_d = RUN;
          end
        end

        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (count_q == WIDTH'(1)) begin
              // Terminal tick; auto_reload matters only here.
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end

        PAUSED: begin
          // Resuming costs one cycle: no decrement on the resume edge.
          if (start && !pause) begin
            state_d = RUN;
          end
        end

        DONE: begin
          count_d = '0;
          if (!pause && start && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign busy      = (state_q == RUN) || (state_q == PAUSED);
  assign done      = (state_q == DONE);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer, plus hand-written
// sequences for auto-reload and pause/resume.
module tb_countdown_timer;

  localparam int W = 12;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         tick = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count_out;
  logic         tc;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    logic         rst;
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         pa;
    logic         tk;
    logic         ar;
    logic [W-1:0] e_count;
    logic         e_tc;
    logic         e_busy;
    logic         e_done;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .pause       (pause),
    .tick        (tick),
    .auto_reload (auto_reload),
    .count_out   (count_out),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare outputs 1 ns after the edge.
  task automatic step(input vec_t v);
    reset       = v.rst;
    load        = v.ld;
    load_value  = v.lv;
    start       = v.st;
    pause       = v.pa;
    tick        = v.tk;
    auto_reload = v.ar;
    @(posedge clock);
    #1;
    check({v.name, ".count"}, 32'(count_out), 32'(v.e_count));
    check({v.name, ".tc"},    32'(tc),        32'(v.e_tc));
    check({v.name, ".busy"},  32'(busy),      32'(v.e_busy));
    check({v.name, ".done"},  32'(done),      32'(v.e_done));
  endtask

  task automatic add(input string name, input logic rst, input logic ld, input int lv,
                     input logic st, input logic pa, input logic tk, input logic ar,
                     input int e_count, input logic e_tc, input logic e_busy,
                     input logic e_done);
    vec_t v;
    v.name = name; v.rst = rst; v.ld = ld; v.lv = W'(lv);
    v.st = st; v.pa = pa; v.tk = tk; v.ar = ar;
    v.e_count = W'(e_count); v.e_tc = e_tc; v.e_busy = e_busy; v.e_done = e_done;
    vecs.push_back(v);
  endtask

  task automatic cyc(input string name, input logic ld, input int lv, input logic st,
                     input logic pa, input logic tk, input logic ar, input int e_count,
                     input logic e_tc, input logic e_busy, input logic e_done);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.ld = ld; v.lv = W'(lv);
    v.st = st; v.pa = pa; v.tk = tk; v.ar = ar;
    v.e_count = W'(e_count); v.e_tc = e_tc; v.e_busy = e_busy; v.e_done = e_done;
    step(v);
  endtask

  initial begin
    //   name        rst ld  lv st pa tk ar   cnt tc busy done
    add("rst0",      1, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("rst1",      1, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("start0",    0, 0,  0, 1, 0, 1, 0,   0, 0, 0, 0);
    // One-shot from 5.
    add("os_load",   0, 1,  5, 0, 0, 0, 0,   5, 0, 0, 0);
    add("os_start",  0, 0,  0, 1, 0, 1, 0,   5, 0, 1, 0);
    add("os_t4",     0, 0,  0, 0, 0, 1, 0,   4, 0, 1, 0);
    add("os_t3",     0, 0,  0, 0, 0, 1, 0,   3, 0, 1, 0);
    add("os_t2",     0, 0,  0, 0, 0, 1, 0,   2, 0, 1, 0);
    add("os_t1",     0, 0,  0, 0, 0, 1, 0,   1, 0, 1, 0);
    add("os_tc",     0, 0,  0, 0, 0, 1, 0,   0, 1, 0, 1);
    add("os_hold",   0, 0,  0, 0, 0, 1, 0,   0, 0, 0, 1);
    // Restart from DONE reloads 5; then load beats a concurrent tick.
    add("dn_start",  0, 0,  0, 1, 0, 1, 0,   5, 0, 1, 0);
    add("dn_t4",     0, 0,  0, 0, 0, 1, 0,   4, 0, 1, 0);
    add("ld_prio",   0, 1,  7, 0, 0, 1, 0,   7, 0, 0, 0);
    add("ld_idle",   0, 0,  0, 0, 0, 1, 0,   7, 0, 0, 0);
    // load_value = 1: tc on the first tick.
    add("one_load",  0, 1,  1, 0, 0, 0, 0,   1, 0, 0, 0);
    add("one_start", 0, 0,  0, 1, 0, 1, 0,   1, 0, 1, 0);
    add("one_tc",    0, 0,  0, 0, 0, 1, 0,   0, 1, 0, 1);
    // Load 4, run to DONE, restart, reset at count 2.
    add("r_load",    0, 1,  4, 0, 0, 0, 0,   4, 0, 0, 0);
    add("r_start",   0, 0,  0, 1, 0, 1, 0,   4, 0, 1, 0);
    add("r_t3",      0, 0,  0, 0, 0, 1, 0,   3, 0, 1, 0);
    add("r_t2",      0, 0,  0, 0, 0, 1, 0,   2, 0, 1, 0);
    add("r_t1",      0, 0,  0, 0, 0, 1, 0,   1, 0, 1, 0);
    add("r_tc",      0, 0,  0, 0, 0, 1, 0,   0, 1, 0, 1);
    add("r_restart", 0, 0,  0, 1, 0, 0, 0,   4, 0, 1, 0);
    add("r_t3b",     0, 0,  0, 0, 0, 1, 0,   3, 0, 1, 0);
    add("r_t2b",     0, 0,  0, 0, 0, 1, 0,   2, 0, 1, 0);
    add("r_reset",   1, 0,  0, 0, 0, 1, 0,   0, 0, 0, 0);
    add("r_after",   0, 0,  0, 0, 0, 1, 0,   0, 0, 0, 0);
    // Reset on the terminal tick suppresses the pending tc.
    add("p_load",    0, 1,  1, 0, 0, 0, 0,   1, 0, 0, 0);
    add("p_start",   0, 0,  0, 1, 0, 1, 0,   1, 0, 1, 0);
    add("p_reset",   1, 0,  0, 0, 0, 1, 0,   0, 0, 0, 0);
    add("p_after",   0, 0,  0, 0, 0, 1, 0,   0, 0, 0, 0);

    @(negedge clock);
    foreach (vecs[i]) step(vecs[i]);

    // Auto-reload period 3: after start, count is 3 - ((i+1) mod 3), tc on each reload.
    cyc("ar_load",  1, 3, 0, 0, 0, 1,  3, 0, 0, 0);
    cyc("ar_start", 0, 0, 1, 0, 1, 1,  3, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      int ph;
      ph = (i + 1) % 3;
      cyc($sformatf("ar_%0d", i), 0, 0, 0, 0, 1, 1, 3 - ph, ph == 0, 1, 0);
    end
    cyc("ar_off2",  0, 0, 0, 0, 1, 0,  2, 0, 1, 0);
    cyc("ar_off1",  0, 0, 0, 0, 1, 0,  1, 0, 1, 0);
    cyc("ar_offtc", 0, 0, 0, 0, 1, 0,  0, 1, 0, 1);

    // Pause/resume from 10.
    cyc("pr_load",  1, 10, 0, 0, 0, 0, 10, 0, 0, 0);
    cyc("pr_start", 0, 0,  1, 0, 1, 0, 10, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("pr_run%0d", i), 0, 0, 0, 0, 1, 0, 9 - i, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("pr_pause%0d", i), 0, 0, 0, 1, 1, 0, 6, 0, 1, 0);
    cyc("pr_ps_both", 0, 0, 1, 1, 1, 0, 6, 0, 1, 0);
    cyc("pr_ps_held", 0, 0, 0, 0, 1, 0, 6, 0, 1, 0);
    cyc("pr_resume",  0, 0, 1, 0, 1, 0, 6, 0, 1, 0);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("pr_dec%0d", i), 0, 0, 0, 0, 1, 0, 5 - i, 0, 1, 0);
    cyc("pr_tc",      0, 0, 0, 0, 1, 0, 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counter: the load/countdown counterpart to the team's free-running 12-bit up-counter.
- Loaded with a terminal value, it decrements on qualified ticks and emits a one-cycle terminal-count pulse at zero.
- Optional auto-reload gives periodic pulses.
- Used as a timeout/period generator next to the up-counter in the same clock domain.

Parameters:
- WIDTH, 12, counter and load-value width in bits.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_value into reload register and counter.
- load_value  input  WIDTH  start/period value.
- start  input  1  begin or resume counting.
- pause  input  1  freeze counting while running.
- tick  input  1  decrement qualifier (1 = count this cycle).
- auto_reload  input  1  1 = reload on terminal count and keep running.
- count_out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, one cycle, registered.
- busy  output  1  high in RUN or PAUSED.
- done  output  1  high in DONE.

Behaviour:
- Reset values: count_out=0, reload_reg=0, tc=0, state=IDLE; therefore busy=0 and done=0.
- Command priority per cycle: reset > load > pause > start > tick.
- States: IDLE, RUN, PAUSED, DONE (2-bit encoding). busy and done are decoded from state.
- tc defaults to 0 every cycle. It is high only in the cycle after a terminal tick.
- load, any state:
  - reload_reg <= load_value; count_out <= load_value; state <= IDLE.
  - A concurrent tick is ignored.
- IDLE:
  - start with count_out != 0 -> RUN.
  - start with count_out == 0 is ignored; stays IDLE.
- RUN:
  - pause -> PAUSED; count held.
  - Otherwise, tick with count_out > 1 -> count_out <= count_out - 1.
  - Terminal tick (tick with count_out == 1):
    - tc <= 1.
    - If auto_reload=1: count_out <= reload_reg, stay RUN.
    - Else: count_out <= 0, state <= DONE.
  - tick=0: hold.
  - auto_reload is sampled at the terminal tick only.
- PAUSED:
  - start with pause=0 -> RUN; no decrement that cycle even if tick=1.
  - pause and start together: stays PAUSED.
- DONE:
  - Holds count_out=0.
  - start with reload_reg != 0 -> count_out <= reload_reg, state <= RUN.
  - start with reload_reg == 0 is ignored.
- Latency and period:
  - Decrement is visible on count_out the cycle after the qualifying tick edge.
  - With tick held high, a load of N then start gives tc N cycles after the first RUN cycle.
  - Auto-reload period is exactly reload_reg ticks.
- No wrap-around: the counter never decrements below 0, and never holds 0 while in RUN.
- load_value = 1 is legal: tc on the first tick.
- Reset mid-count returns all outputs to reset values on the next edge, including clearing a pending tc.

Decomposition:
- Shared package timer_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3.
  - Default WIDTH constant shared with the up-counter.
- Single module, no sub-modules. The FSM and datapath are small enough to keep together.

Test Plan:
- Reset then idle: hold reset 2 cycles -> count_out=0, tc=0, busy=0, done=0. start with count 0 is ignored.
- One-shot: load 5, start, tick=1 continuously:
  - count_out steps 5,4,3,2,1,0.
  - tc high exactly one cycle, coincident with count_out=0.
  - done=1, busy=0 afterward.
- Auto-reload:
  - load 3, auto_reload=1, start, tick=1 for 12 cycles -> tc pulses every 3 cycles, count_out sequence 3,2,1,3,2,1...
  - Then drop auto_reload -> next terminal tick ends in DONE.
- Pause/resume:
  - load 10, start, run 4 ticks (count=6), pause 5 cycles with tick=1 -> count_out stays 6.
  - start -> first decrement one cycle later, tc after 6 further ticks.
- Priority:
  - load 7 while RUN with tick=1 -> count_out=7, state IDLE, no decrement.
  - pause+start together while PAUSED -> stays PAUSED.
- Restart and mid-run reset:
  - From DONE after load 4, start -> count_out=4, RUN.
  - reset asserted at count 2 -> all outputs return to zero next edge, and no tc follows.
